memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage of the 64-bit RISC-V core. It sits directly downstream of the execute stage, consumes `execute_data_t`, and performs the data-bus transaction for loads and stores. Stores get byte-lane alignment and strobes; load data is extracted and extended. The stage produces `memory_data_t` for writeback and holds one instruction at a time behind a valid/ready handshake.

## Interface
Parameters:
- None. Widths come from the `common` and `pipes` packages: `word_t` is 64 bits, `addr_t` is 64 bits, `strobe_t` is 8 bits.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `dataE` holds a valid instruction
- `in_ready`  out  1  stage accepts `dataE` this cycle
- `dataE`  in  `execute_data_t`  uses `aluout` (effective address or result), `memdata` (store data), `dst`, `ctl`, `raw_instr`
- `out_valid`  out  1  `dataM` is valid
- `out_ready`  in  1  writeback consumes `dataM` this cycle
- `dataM`  out  `memory_data_t`  fields: `result`, `dst`, `ctl`, `raw_instr`, `misalign`
- `dreq`  out  `dbus_req_t`  fields: `valid`, `addr`, `size`, `strobe`, `data`
- `dresp`  in  `dbus_resp_t`  fields: `addr_ok`, `data_ok`, `data`

## Operation
- FSM states:
  - IDLE: empty.
  - REQ: `dreq.valid`=1.
  - WAIT: address accepted, awaiting data.
  - DONE: `out_valid`=1.
- Acceptance: an instruction is accepted when `in_valid && in_ready`, with `in_ready = (IDLE) || (DONE && out_ready)`. Accepting latches `dataE` into an internal register.
- Routing on accept:
  - Instruction is neither `ctl.memread` nor `ctl.memwrite` -> DONE, with `result = aluout`.
  - Memory access misaligned (`addr % size != 0`) -> DONE, with `misalign`=1, `result`=0, and no bus request.
  - Otherwise -> REQ.
- Request (REQ): `dreq.addr` = latched `aluout`; `dreq.size` = `ctl.msize`.
  - Store: `strobe = mask(size) << addr[2:0]` and `data = memdata << (8*addr[2:0])`.
  - Load: `strobe`=0.
  - All `dreq` fields come from the latched register and stay stable for the whole of REQ.
- REQ exits:
  - `addr_ok && data_ok` -> DONE.
  - `addr_ok` only -> WAIT.
  - Neither -> stay in REQ.
- WAIT: `data_ok` -> DONE; otherwise stay in WAIT.
- Load capture: on `data_ok`, `result = ext(dresp.data >> 8*addr[2:0])`. The value is truncated to 1, 2, 4 or 8 bytes, then sign-extended if `ctl.memsext`, else zero-extended. Stores set `result`=0.
- DONE exits:
  - `out_ready && in_valid` -> route the new instruction as above (back-to-back operation).
  - `out_ready && !in_valid` -> IDLE.
  - `!out_ready` -> hold; `dataM` stays stable.
- `dresp` is ignored in IDLE and DONE; a stray `data_ok` there has no effect.

## Timing
- Reset (async assert, sync release): state IDLE, `out_valid`=0, `dreq.valid`=0, `dataM`=0, `in_ready`=1.
- Reset mid-transaction abandons the bus access. The data bus must be reset by the same `reset_n`.
- Latency from accept to `out_valid`:
  - non-memory or misaligned: 1 cycle;
  - memory access with same-cycle `addr_ok` and `data_ok`: 2 cycles;
  - otherwise: 2 cycles plus the bus wait cycles.
- Throughput: 1 instruction per cycle for a non-memory stream with `out_ready`=1.
- `dreq.valid` is a registered state decode; it never depends combinationally on `dresp`.
- `in_ready` depends combinationally on `out_ready` only.

## Structure
- `pipes` package additions:
  - `msize_t` (MSIZE1, MSIZE2, MSIZE4, MSIZE8);
  - `control_t` fields `memread`, `memwrite`, `msize`, `memsext`;
  - `execute_data_t.memdata`;
  - `memory_data_t`.
- `common` package provides `dbus_req_t`, `dbus_resp_t` and `strobe_t`.
- FSM state enum is local to the module.
- One combinational sub-module, `memalign`: takes addr[2:0], size, sext, store data and load data; produces strobe, shifted store data and extended load result. Unit-testable alone.

## Test plan
- Non-memory stream: `aluout`=0x1234 with `in_valid`=1 and `out_ready`=1 every cycle -> `out_valid` from cycle 1, `result`=0x1234, one instruction per cycle, `dreq.valid` never 1.
- Load byte, signed: addr 0x1003, `dresp.data`=0x0000_0000_8000_0000 returned with `addr_ok` and `data_ok` in the same cycle -> `result`=0xFFFF_FFFF_FFFF_FF80 (0x80 sign-extended); with `memsext`=0 -> 0x80.
- Store half: addr 0x1006, `memdata`=0xBEEF -> `dreq.strobe`=0xC0, `dreq.data[63:48]`=0xBEEF. Delaying `addr_ok` 3 cycles holds `dreq` stable; then `addr_ok` followed 2 cycles later by `data_ok` -> `out_valid` 1 cycle after `data_ok`.
- Misaligned word at addr 0x1002 -> no `dreq.valid`, `out_valid` next cycle with `misalign`=1.
- Backpressure: `out_ready`=0 for 4 cycles in DONE -> `dataM` stable, `in_ready`=0. Then raising `out_ready` with `in_valid` high -> next instruction accepted in the same cycle.
- Assert `reset_n`=0 while in WAIT -> all outputs take reset values immediately. A `data_ok` arriving after reset release is ignored.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline payloads, data-bus request/response
// and the access-size helpers used by both the stage and its alignment unit.
package memory_stage_pkg;

   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;
   typedef logic [7:0]  strobe_t;
   typedef logic [4:0]  creg_addr_t;
   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic   memread;
      logic   memwrite;
      msize_t msize;
      logic   memsext;
   } control_t;

   typedef struct packed {
      word_t      aluout;
      word_t      memdata;
      creg_addr_t dst;
      control_t   ctl;
      instr_t     raw_instr;
   } execute_data_t;

   typedef struct packed {
      word_t      result;
      creg_addr_t dst;
      control_t   ctl;
      instr_t     raw_instr;
      logic       misalign;
   } memory_data_t;

   typedef struct packed {
      logic    valid;
      addr_t   addr;
      msize_t  size;
      strobe_t strobe;
      word_t   data;
   } dbus_req_t;

   typedef struct packed {
      logic  addr_ok;
      logic  data_ok;
      word_t data;
   } dbus_resp_t;

   // Byte-lane mask of an access before it is shifted to its lane.
   function automatic strobe_t size_mask(input msize_t size);
      case (size)
         MSIZE1:  return 8'h01;
         MSIZE2:  return 8'h03;
         MSIZE4:  return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] addr_lo, input msize_t size);
      case (size)
         MSIZE1:  return 1'b0;
         MSIZE2:  return addr_lo[0];
         MSIZE4:  return |addr_lo[1:0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/memory_stage_memalign.sv
// Combinational byte-lane alignment: store strobes and shifted store data,
// plus load extraction with sign/zero extension.
module memory_stage_memalign
   import memory_stage_pkg::*;
(
   input  logic [2:0] addr_lo,
   input  msize_t     size,
   input  logic       sext,
   input  word_t      store_data,
   input  word_t      load_data,
   output strobe_t    strobe,
   output word_t      store_shifted,
   output word_t      load_result
);

   word_t load_shifted;

   always_comb begin
      strobe        = size_mask(size) << addr_lo;
      store_shifted = store_data << {addr_lo, 3'b000};
      load_shifted  = load_data >> {addr_lo, 3'b000};
      case (size)
         MSIZE1:  load_result = {{56{sext & load_shifted[7]}},  load_shifted[7:0]};
         MSIZE2:  load_result = {{48{sext & load_shifted[15]}}, load_shifted[15:0]};
         MSIZE4:  load_result = {{32{sext & load_shifted[31]}}, load_shifted[31:0]};
         default: load_result = load_shifted;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: one instruction in flight, drives the data bus for
// loads/stores and hands a registered memory_data_t to writeback.
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  execute_data_t dataE,
   output logic          out_valid,
   input  logic          out_ready,
   output memory_data_t  dataM,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   execute_data_t inst_q, inst_d;
   memory_data_t  out_q, out_d;

   strobe_t st_strobe;
   word_t   st_data;
   word_t   ld_result;

   memory_stage_memalign u_memalign (
      .addr_lo       (inst_q.aluout[2:0]),
      .size          (inst_q.ctl.msize),
      .sext          (inst_q.ctl.memsext),
      .store_data    (inst_q.memdata),
      .load_data     (dresp.data),
      .strobe        (st_strobe),
      .store_shifted (st_data),
      .load_result   (ld_result)
   );

   always_comb begin
      state_d  = state_q;
      inst_d   = inst_q;
      out_d    = out_q;
      in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

      case (state_q)
         IDLE, DONE: begin
            if ((state_q == DONE) && out_ready) begin
               state_d = IDLE;
            end
            if (in_valid && in_ready) begin
               inst_d          = dataE;
               out_d.dst       = dataE.dst;
               out_d.ctl       = dataE.ctl;
               out_d.raw_instr = dataE.raw_instr;
               out_d.misalign  = 1'b0;
               out_d.result    = dataE.aluout;
               if (dataE.ctl.memread || dataE.ctl.memwrite) begin
                  out_d.result = '0;
                  // Misaligned accesses complete at once without touching the bus.
                  if (is_misaligned(dataE.aluout[2:0], dataE.ctl.msize)) begin
                     out_d.misalign = 1'b1;
                     state_d        = DONE;
                  end else begin
                     state_d = REQ;
                  end
               end else begin
                  state_d = DONE;
               end
            end
         end
         REQ, WAIT: begin
            if ((state_q == REQ) && dresp.addr_ok && !dresp.data_ok) begin
               state_d = WAIT;
            end
            if (dresp.data_ok && ((state_q == WAIT) || dresp.addr_ok)) begin
               state_d         = DONE;
               out_d.dst       = inst_q.dst;
               out_d.ctl       = inst_q.ctl;
               out_d.raw_instr = inst_q.raw_instr;
               out_d.misalign  = 1'b0;
               out_d.result    = inst_q.ctl.memwrite ? '0 : ld_result;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid   = (state_q == DONE);
      dataM       = out_q;
      dreq.valid  = (state_q == REQ);
      dreq.addr   = inst_q.aluout;
      dreq.size   = inst_q.ctl.msize;
      dreq.strobe = inst_q.ctl.memwrite ? st_strobe : '0;
      dreq.data   = st_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         inst_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed cases then randomized traffic
// with a responsive data-bus model and random writeback backpressure.
module tb_memory_stage;
   import memory_stage_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid;
   logic          in_ready;
   execute_data_t dataE;
   logic          out_valid;
   logic          out_ready;
   memory_data_t  dataM;
   dbus_req_t     dreq;
   dbus_resp_t    dresp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] result;
      logic        misalign;
      logic [4:0]  dst;
      logic [31:0] raw;
   } exp_t;

   typedef struct {
      logic [63:0] addr;
      msize_t      size;
      logic        is_store;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [63:0] rdata;
      int          adly;
      int          ddly;
   } bus_t;

   exp_t exp_q[$];
   bus_t bus_q[$];
   logic rdy_random = 1'b0;
   logic stray_en   = 1'b1;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dataE     (dataE),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dataM     (dataM),
      .dreq      (dreq),
      .dresp     (dresp)
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Reference: result of one instruction from the architectural rules.
   function automatic exp_t model(input execute_data_t e, input logic [63:0] rdata);
      exp_t        x;
      int          bytes;
      int          lane;
      logic [63:0] v;
      logic [63:0] m;
      bytes      = 1 << int'(e.ctl.msize);
      x.dst      = e.dst;
      x.raw      = e.raw_instr;
      x.misalign = 1'b0;
      x.result   = e.aluout;
      if (e.ctl.memread || e.ctl.memwrite) begin
         x.result = 64'd0;
         if ((e.aluout % bytes) != 0) begin
            x.misalign = 1'b1;
         end else if (e.ctl.memread) begin
            lane = int'(e.aluout % 8);
            v    = rdata >> (8 * lane);
            m    = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * bytes)) - 64'd1);
            v    = v & m;
            if (e.ctl.memsext && v[8 * bytes - 1]) v = v | ~m;
            x.result = v;
         end
      end
      return x;
   endfunction

   task automatic send(input int kind, input msize_t sz, input logic sext,
                       input logic [63:0] aluout, input logic [63:0] memdata,
                       input logic [63:0] rdata, input int adly, input int ddly,
                       input bit expect_out, output int stalls);
      execute_data_t e;
      exp_t          x;
      bus_t          b;
      int            bytes;
      int            lane;
      e.aluout       = aluout;
      e.memdata      = memdata;
      e.dst          = 5'($urandom);
      e.raw_instr    = $urandom;
      e.ctl.memread  = (kind == 1);
      e.ctl.memwrite = (kind == 2);
      e.ctl.msize    = sz;
      e.ctl.memsext  = sext;
      x              = model(e, rdata);
      dataE          = e;
      in_valid       = 1'b1;
      stalls         = 0;
      @(negedge clk);
      while (!in_ready && stalls < 200) begin
         @(negedge clk);
         stalls++;
      end
      check("accept", in_ready, 1'b1);
      bytes = 1 << int'(sz);
      lane  = int'(aluout % 8);
      if (kind != 0 && (aluout % bytes) == 0) begin
         b.addr     = aluout;
         b.size     = sz;
         b.is_store = (kind == 2);
         b.strobe   = (kind == 2) ? 8'(((1 << bytes) - 1) << lane) : 8'h00;
         b.data     = memdata << (8 * lane);
         b.rdata    = rdata;
         b.adly     = adly;
         b.ddly     = ddly;
         bus_q.push_back(b);
      end
      if (expect_out) exp_q.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Data-bus model: serves requests in order with per-request delays.
   initial begin
      bus_t      b;
      dbus_req_t r;
      dresp = '0;
      forever begin
         @(negedge clk);
         dresp.addr_ok = 1'b0;
         dresp.data_ok = 1'b0;
         dresp.data    = rand64();
         if (reset_n) begin
            if (dreq.valid) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_dreq actual=addr %0h required=no request", dreq.addr);
               end else begin
                  b = bus_q.pop_front();
                  r = dreq;
                  check("dreq_addr", dreq.addr, b.addr);
                  check("dreq_size", dreq.size, b.size);
                  check("dreq_strobe", dreq.strobe, b.strobe);
                  if (b.is_store) check("dreq_data", dreq.data, b.data);
                  for (int k = 0; k < b.adly; k++) begin
                     @(negedge clk);
                     check("dreq_stable", dreq, r);
                  end
                  dresp.addr_ok = 1'b1;
                  if (b.ddly == 0) begin
                     dresp.data_ok = 1'b1;
                     dresp.data    = b.rdata;
                  end else begin
                     @(negedge clk);
                     dresp.addr_ok = 1'b0;
                     check("dreq_valid_in_wait", dreq.valid, 1'b0);
                     repeat (b.ddly - 1) @(negedge clk);
                     dresp.data_ok = 1'b1;
                     dresp.data    = b.rdata;
                  end
               end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
               dresp.data_ok = 1'b1;
               dresp.addr_ok = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each writeback handshake, checks holds.
   initial begin
      memory_data_t prev;
      logic         hold;
      exp_t         x;
      hold = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", out_valid, 1'b1);
               check("hold_dataM", dataM, prev);
            end
            if (out_valid) begin
               check("in_ready_in_done", in_ready, out_ready);
               if (out_ready) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_out actual=result %0h required=no output", dataM.result);
                  end else begin
                     x = exp_q.pop_front();
                     check("result", dataM.result, x.result);
                     check("misalign", dataM.misalign, x.misalign);
                     check("dst", dataM.dst, x.dst);
                     check("raw_instr", dataM.raw_instr, x.raw);
                  end
               end
            end
            hold = out_valid && !out_ready;
            prev = dataM;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          stalls;
      int          total;
      int          waited;
      int          kind;
      int          bytes;
      int          cnt;
      msize_t      sz;
      logic [63:0] a;
      in_valid = 1'b0;
      dataE    = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_dreq_valid", dreq.valid, 1'b0);
      check("rst_dataM", dataM, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      total = 0;
      for (int n = 0; n < 8; n++) begin
         send(0, MSIZE8, 1'b0, 64'h1234, rand64(), 64'd0, 0, 0, 1'b1, stalls);
         total += stalls;
      end
      check("nonmem_throughput_stalls", total, 0);

      send(1, MSIZE1, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b1, stalls);
      send(1, MSIZE1, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b1, stalls);
      send(2, MSIZE2, 1'b0, 64'h1006, 64'hBEEF, 64'd0, 3, 2, 1'b1, stalls);
      send(1, MSIZE4, 1'b1, 64'h1002, 64'd0, rand64(), 0, 0, 1'b1, stalls);

      rdy_random = 1'b1;
      for (int n = 0; n < 300; n++) begin
         kind  = $urandom_range(0, 2);
         sz    = msize_t'($urandom_range(0, 3));
         bytes = 1 << int'(sz);
         a     = rand64();
         if ($urandom_range(0, 4) != 0) a = a & ~64'(bytes - 1);
         send(kind, sz, 1'($urandom_range(0, 1)), a, rand64(), rand64(),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, stalls);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      rdy_random = 1'b0;
      waited = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check("drain_exp_q", exp_q.size(), 0);
      check("drain_bus_q", bus_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;

      // Reset while a load is parked in WAIT; its late data_ok must be ignored.
      stray_en = 1'b0;
      send(1, MSIZE8, 1'b0, 64'h2000, 64'd0, rand64(), 0, 6, 1'b0, stalls);
      @(negedge clk);
      check("wait_test_req", dreq.valid, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("wait_test_no_req", dreq.valid, 1'b0);
      check("wait_test_no_out", out_valid, 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_dreq_valid", dreq.valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_dataM", dataM, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid || dreq.valid) cnt++;
      end
      check("post_reset_quiet_cycles", cnt, 0);
      check("post_reset_dataM", dataM, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
